// File: rtl/scc_fetch_unit.sv
// SCC instruction fetch stage: PC, imem read issue, prefetch FIFO, redirect/halt handling.
// Optional build macro FETCH_STALL_CNT_EN adds the stall_cnt output.
module scc_fetch_unit #(
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              redirect_v,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_in,
  output logic              err_pc_wrap,
  output logic              fetch_idle
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_issued_pc;
  logic              r_inflight;
  logic              r_err;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_mem_inst [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_mem_pc   [FIFO_DEPTH];

  logic [CNT_W:0]    w_occ;
  logic              w_run;
  logic              w_issue;
  logic              w_redirect;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (halt_in) w_state_nxt = ST_HALT;
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Halt beats redirect, and redirect blocks issue and masks the head in the same cycle.
  always_comb begin
    w_run       = (r_state == ST_RUN);
    w_occ       = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    w_redirect  = rst && clk_en && w_run && redirect_v && !halt_in;
    w_issue     = rst && clk_en && w_run && !halt_in && !redirect_v &&
                  (w_occ < (CNT_W + 1)'(FIFO_DEPTH));
    w_valid     = rst && (r_count != '0) && !w_redirect;
    w_push      = rst && clk_en && r_inflight && !w_redirect;
    w_pop       = clk_en && w_valid && inst_ready;
    imem_req    = w_issue;
    imem_addr   = rst ? r_pc : RESET_PC;
    inst_valid  = w_valid;
    inst_out    = rst ? r_mem_inst[r_rd_ptr] : '0;
    pc_out      = rst ? r_mem_pc[r_rd_ptr] : '0;
    err_pc_wrap = rst && r_err;
    fetch_idle  = rst && (r_state == ST_HALT) && (r_count == '0) && !r_inflight;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc        <= RESET_PC;
      r_issued_pc <= RESET_PC;
      r_inflight  <= 1'b0;
      r_err       <= 1'b0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else if (clk_en) begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc        <= r_pc + ADDR_W'(1);
        r_issued_pc <= r_pc;
        if (&r_pc) r_err <= 1'b1;
      end else if (w_redirect) begin
        r_pc <= redirect_pc;
      end
      if (w_redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]   <= r_issued_pc;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (clk_en && w_run && w_valid && !inst_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = rst ? r_stall_cnt : '0;
`endif

endmodule

// File: tb/tb_scc_fetch_unit.sv
// Scoreboard bench for scc_fetch_unit: expected PC stream queue, imem model, randomized phase.
module tb_scc_fetch_unit;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_en = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [DW-1:0] inst_out;
  logic [AW-1:0] pc_out;
  logic          redirect_v = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          halt_in = 1'b0;
  logic          err_pc_wrap;
  logic          fetch_idle;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  logic          halted = 1'b0;
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] e;

  scc_fetch_unit #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .RESET_PC  (16'h0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .pc_out     (pc_out),
    .redirect_v (redirect_v),
    .redirect_pc(redirect_pc),
    .halt_in    (halt_in),
    .err_pc_wrap(err_pc_wrap),
    .fetch_idle (fetch_idle)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a} + 32'h0000_0100;
  endfunction

  // Synchronous instruction memory: data appears one enabled cycle after the request.
  always @(posedge clk) begin
    if (clk_en && imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every accepted instruction must be the next address of the current stream.
  always @(negedge clk) begin
    if (rst && clk_en && inst_valid && inst_ready) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL stream: accepted pc %h with no expected entry", pc_out);
      end else begin
        e = exp_q.pop_front();
        check("pc_out", 32'(pc_out), 32'(e));
        check("inst_out", inst_out, mem_word(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [15:0] p);
    logic [15:0] t;
    exp_q.delete();
    t = p;
    repeat (1024) begin
      exp_q.push_back(t);
      t = t + 16'd1;
    end
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    redirect_v = 1'b0;
    halt_in    = 1'b0;
    clk_en     = 1'b1;
    halted     = 1'b0;
    restart(16'h0000);
    @(negedge clk);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_err", 32'(err_pc_wrap), 32'd0);
    check("rst_idle", 32'(fetch_idle), 32'd0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic do_redirect(input logic [15:0] p);
    redirect_v  = 1'b1;
    redirect_pc = p;
    restart(p);
    @(negedge clk);
    check("redir_gate", 32'(inst_valid), 32'd0);
    check("redir_noreq", 32'(imem_req), 32'd0);
    tick();
    redirect_v = 1'b0;
  endtask

  initial begin
    int n_req;
    tick();

    // Reset, then hold decode off: latency and prefetch depth.
    inst_ready = 1'b0;
    do_reset();
    n_req = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) n_req++;
      if (i == 0) check("first_addr", 32'(imem_addr), 32'd0);
      if (i < 2)  check("lat_valid_lo", 32'(inst_valid), 32'd0);
      if (i == 2) check("lat_valid_hi", 32'(inst_valid), 32'd1);
      if (i == 9) check("held_head_pc", 32'(pc_out), 32'd0);
      tick();
    end
    check("fill_issues", 32'(n_req), 32'd2);
    check("fill_pc", 32'(imem_addr), 32'd2);
    check("fill_noreq", 32'(imem_req), 32'd0);

    // Stream with decode always ready.
    inst_ready = 1'b1;
    n_acc = 0;
    repeat (20) tick();
    n_checks++;
    if (n_acc >= 10) n_pass++;
    else $display("FAIL stream_rate: got %0d accepts expected at least 10", n_acc);

    // Redirect with a read in flight; the stale word must never surface.
    do_redirect(16'h0040);
    repeat (10) tick();

    // Redirect to the top of the address space: wrap and sticky error.
    do_redirect(16'hFFFF);
    repeat (10) tick();
    check("wrap_err", 32'(err_pc_wrap), 32'd1);

    // Halt together with redirect: halt wins, the old stream drains in order.
    halt_in     = 1'b1;
    redirect_v  = 1'b1;
    redirect_pc = 16'h0123;
    @(negedge clk);
    check("halt_noreq", 32'(imem_req), 32'd0);
    tick();
    halt_in    = 1'b0;
    redirect_v = 1'b0;
    halted     = 1'b1;
    n_req = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) n_req++;
      if (fetch_idle) break;
      tick();
    end
    check("halt_issues", 32'(n_req), 32'd0);
    check("halt_idle", 32'(fetch_idle), 32'd1);
    check("halt_empty", 32'(inst_valid), 32'd0);
    tick();
    redirect_v  = 1'b1;
    redirect_pc = 16'h0080;
    @(negedge clk);
    check("halt_redir_noreq", 32'(imem_req), 32'd0);
    tick();
    redirect_v = 1'b0;
    @(negedge clk);
    check("halt_redir_idle", 32'(fetch_idle), 32'd1);
    check("halt_redir_req", 32'(imem_req), 32'd0);
    check("err_sticky", 32'(err_pc_wrap), 32'd1);
    tick();

    // Reset mid-stream after a wrap.
    do_reset();
    repeat (8) tick();
    do_redirect(16'hFFFE);
    repeat (8) tick();
    check("wrap_err2", 32'(err_pc_wrap), 32'd1);
    rst = 1'b0;
    restart(16'h0000);
    @(negedge clk);
    check("midrst_valid", 32'(inst_valid), 32'd0);
    check("midrst_err", 32'(err_pc_wrap), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_addr", 32'(imem_addr), 32'd0);
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_valid", 32'(inst_valid), 32'd0);
    check("post_rst_err", 32'(err_pc_wrap), 32'd0);
    tick();

    // Randomized clock-enable, backpressure and redirects.
    for (int i = 0; i < 2000; i++) begin
      clk_en     = ($urandom_range(0, 9) != 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        redirect_v  = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
        if (clk_en) restart(redirect_pc);
      end else begin
        redirect_v = 1'b0;
      end
      tick();
    end
    clk_en     = 1'b1;
    inst_ready = 1'b1;
    redirect_v = 1'b0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
